// File: rtl/dbus_peri_master.sv
// -----------------------------------------------------------------------------
// dbus_peri_master
//
// Initiator side of the peripheral data bus. Takes one load/store at a time
// from the core LSU, decodes the address into a one-hot peripheral select,
// presents the registered request to the selected slave and waits for that
// slave's registered ack. Read data (or an error for an unmapped address or
// an access that timed out) is returned to the LSU as a one-cycle pulse.
//
// Address map: addr[31:16] must equal PERI_BASE; addr[11:8] selects the slot;
// the slave decodes addr[7:0] itself.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   lsu_req_i        LSU request, accepted when lsu_req_i & lsu_ready_o
//   lsu_w_en_i       1 = write, 0 = read
//   lsu_addr_i       byte address
//   lsu_w_data_i     write data
//   lsu_ready_o      master idle and able to accept a request
//   lsu_rsp_valid_o  one-cycle response pulse
//   lsu_r_data_o     read data, qualified by lsu_rsp_valid_o
//   lsu_err_o        decode or timeout error, qualified by lsu_rsp_valid_o
//   peri_req_o       bus request to the peripherals
//   peri_sel_o       one-hot slave select
//   peri_addr_o      registered address
//   peri_w_data_o    registered write data
//   peri_w_en_o      registered write enable
//   peri_ack_i       per-slave ack
//   peri_r_data_i    per-slave read data, slot k in bits [32k+31:32k]
// -----------------------------------------------------------------------------
module dbus_peri_master #(
  parameter int unsigned NUM_PERI       = 4,
  parameter logic [15:0] PERI_BASE      = 16'h8000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     lsu_req_i,
  input  logic                     lsu_w_en_i,
  input  logic [31:0]              lsu_addr_i,
  input  logic [31:0]              lsu_w_data_i,
  output logic                     lsu_ready_o,
  output logic                     lsu_rsp_valid_o,
  output logic [31:0]              lsu_r_data_o,
  output logic                     lsu_err_o,
  output logic                     peri_req_o,
  output logic [NUM_PERI-1:0]      peri_sel_o,
  output logic [31:0]              peri_addr_o,
  output logic [31:0]              peri_w_data_o,
  output logic                     peri_w_en_o,
  input  logic [NUM_PERI-1:0]      peri_ack_i,
  input  logic [32*NUM_PERI-1:0]   peri_r_data_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [NUM_PERI-1:0]  sel_q;
  logic [31:0]          addr_q;
  logic [31:0]          w_data_q;
  logic                 w_en_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [31:0]          r_data_q;
  logic                 err_q;

  logic                 accept;
  logic                 dec_hit;
  logic [NUM_PERI-1:0]  dec_sel;
  logic                 ack_hit;
  logic                 timeout_hit;
  logic [31:0]          slot_r_data;

  // ---------------------------------------------------------------------------
  // Address decode and slave-side qualifiers
  // ---------------------------------------------------------------------------
  assign accept = lsu_req_i && (state_q == S_IDLE);

  // The slot field is widened by one bit so NUM_PERI = 16 compares correctly.
  assign dec_hit = (lsu_addr_i[31:16] == PERI_BASE) &&
                   ({1'b0, lsu_addr_i[11:8]} < 5'(NUM_PERI));

  // NOTE: every signal written in an always_comb gets a default before any
  // conditional assignment, otherwise synthesis infers a latch.
  always_comb begin
    dec_sel = '0;
    for (int k = 0; k < NUM_PERI; k++) begin
      dec_sel[k] = (lsu_addr_i[11:8] == 4'(k));
    end
  end

  // Only the selected slave's ack counts; stray acks on other bits are masked.
  assign ack_hit = |(peri_ack_i & sel_q);

  // The counter holds the number of BUSY cycles already completed, so the
  // cycle in which it reads TIMEOUT_CYCLES-1 is the last allowed cycle.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // sel_q is one-hot, so an AND-OR mux picks the selected slot's read data.
  always_comb begin
    slot_r_data = '0;
    for (int k = 0; k < NUM_PERI; k++) begin
      if (sel_q[k]) begin
        slot_r_data = slot_r_data | peri_r_data_i[32*k +: 32];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = dec_hit ? S_BUSY : S_RESP;
        end
      end
      S_BUSY: begin
        // An ack in the timeout cycle still counts as a successful access.
        if (ack_hit || timeout_hit) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Request and select are decoded from the state register alone, so an
  // asynchronous reset drops them at once and RESP cleanly ends the request
  // the cycle after the ack.
  always_comb begin
    lsu_ready_o     = 1'b0;
    lsu_rsp_valid_o = 1'b0;
    lsu_r_data_o    = '0;
    lsu_err_o       = 1'b0;
    peri_req_o      = 1'b0;
    peri_sel_o      = '0;
    unique case (state_q)
      S_IDLE: begin
        lsu_ready_o = 1'b1;
      end
      S_BUSY: begin
        peri_req_o = 1'b1;
        peri_sel_o = sel_q;
      end
      S_RESP: begin
        lsu_rsp_valid_o = 1'b1;
        lsu_r_data_o    = r_data_q;
        lsu_err_o       = err_q;
      end
      default: begin
        lsu_ready_o = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request registers, timeout counter, response capture
  // ---------------------------------------------------------------------------
  // NOTE: all of these are a handful of control/data flops (no storage array),
  // so every one is cleared by reset and the outputs are defined from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q    <= '0;
      addr_q   <= '0;
      w_data_q <= '0;
      w_en_q   <= 1'b0;
      cnt_q    <= '0;
      r_data_q <= '0;
      err_q    <= 1'b0;
    end else if (accept) begin
      addr_q   <= lsu_addr_i;
      w_data_q <= lsu_w_data_i;
      w_en_q   <= lsu_w_en_i;
      sel_q    <= dec_hit ? dec_sel : '0;
      cnt_q    <= '0;
      r_data_q <= '0;
      err_q    <= ~dec_hit;
    end else if (state_q == S_BUSY) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (ack_hit) begin
        r_data_q <= w_en_q ? 32'd0 : slot_r_data;
        err_q    <= 1'b0;
      end else if (timeout_hit) begin
        r_data_q <= '0;
        err_q    <= 1'b1;
      end
    end
  end

  assign peri_addr_o   = addr_q;
  assign peri_w_data_o = w_data_q;
  assign peri_w_en_o   = w_en_q;

endmodule
